// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and shared-memory signals of the memory port arbiter
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;
  logic        err;
  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, err
  );
  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters with starvation guard and timeout
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.master bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t state, state_nx;
  logic [SW-1:0] starve_cnt;
  logic [3:0] to_cnt;
  logic if_want, d_want, grant_i, grant_d, busy, done, abort, fin;
  assign bus.stall_if  = bus.if_req & ~bus.if_ack;
  assign bus.stall_mem = bus.d_req & ~bus.d_ack;
  // a requester whose ack is showing this cycle is already served and sits out arbitration
  always_comb begin
    if_want  = bus.if_req & ~bus.if_ack;
    d_want   = bus.d_req & ~bus.d_ack;
    grant_i  = state == IDLE && if_want && (!d_want || starve_cnt == STARVE_MAX);
    grant_d  = state == IDLE && d_want && !grant_i;
    busy     = state != IDLE;
    done     = busy && bus.mem_ready;
    abort    = busy && !bus.mem_ready && to_cnt == TO_LAST;
    fin      = done || abort;
    state_nx = grant_i ? BUSY_I : grant_d ? BUSY_D : fin ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_ack    <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
      bus.err       <= 1'b0;
      starve_cnt    <= '0;
      to_cnt        <= '0;
    end else begin
      bus.if_ack <= state == BUSY_I && fin;
      bus.d_ack  <= state == BUSY_D && fin;
      bus.err    <= bus.err | abort;
      if (busy && !bus.mem_ready) to_cnt <= to_cnt + 4'd1;
      if (grant_i || grant_d) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= grant_d & bus.d_we;
        bus.mem_addr  <= grant_i ? bus.if_addr : bus.d_addr;
        bus.mem_wdata <= grant_i ? '0 : bus.d_wdata;
        to_cnt        <= '0;
        starve_cnt    <= (grant_i || !if_want) ? '0 :
                         starve_cnt == STARVE_MAX ? STARVE_MAX : starve_cnt + 1'b1;
      end
      if (fin) bus.mem_req <= 1'b0;
      if (state == BUSY_I && fin) bus.if_rdata <= abort ? '0 : bus.mem_rdata;
      if (state == BUSY_D && (abort || (done && !bus.mem_we))) bus.d_rdata <= abort ? '0 : bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized requesters and memory responder scored against a transaction-level arbiter model
module tb_mem_port_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 15;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          wt;
  } txn_t;
  logic clk = 1'b0;
  logic reset;
  int compared = 0;
  int mismatched = 0;
  txn_t fq[$];
  txn_t dq[$];
  txn_t cur;
  int exp_port = -1, cur_port = -1, pend_port = -1, ack_now = -1;
  int starve = 0, k = 0, last_k = 0;
  bit active = 0, post_rst = 0, idle = 0, iw = 0, dw = 0;
  logic err_exp = 1'b0;
  logic [31:0] i_last = '0, d_last = '0, r_exp;
  mem_port_arbiter_if bus ();
  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a == 32'h40 ? 32'h012A_4820 : {a[15:0], a[31:16]} ^ 32'hA5A5_1234;
  endfunction
  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 11));
    return r < 9 ? r % 5 : r == 9 ? TIMEOUT - 1 : r == 10 ? TIMEOUT : TIMEOUT + 3;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic fetch_txn(input logic [31:0] a, input int wt);
    int t;
    fq.push_back('{addr: a, we: 1'b0, wdata: 32'h0, wt: wt});
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.if_ack && t < 400);
    chk1("fetch_ack_wait", bus.if_ack, 1'b1);
    @(posedge clk); #1;
    bus.if_req  = 1'b0;
    bus.if_addr = $urandom;
  endtask
  task automatic data_txn(input logic we, input logic [31:0] a, input logic [31:0] wd, input int wt);
    int t;
    dq.push_back('{addr: a, we: we, wdata: wd, wt: wt});
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.d_ack && t < 400);
    chk1("data_ack_wait", bus.d_ack, 1'b1);
    @(posedge clk); #1;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'($urandom);
    bus.d_addr  = $urandom;
    bus.d_wdata = $urandom;
  endtask
  task automatic fetch_rand(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      fetch_txn({16'h0000, 14'($urandom), 2'b00}, pick_wait());
    end
  endtask
  task automatic data_rand(input int n, input int gap, input bit allow_to);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
      data_txn(1'($urandom), {16'h8000, 14'($urandom), 2'b00}, $urandom,
               allow_to ? pick_wait() : int'($urandom_range(0, 4)));
    end
  endtask
  // fetch backs off only during data ack cycles, so data keeps winning until the starvation guard trips
  task automatic starve_fetch();
    int t;
    bit got;
    fq.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'h0, wt: 1});
    bus.if_addr = 32'h300;
    got = 0;
    t = 0;
    while (!got && t < 400) begin
      bus.if_req = !bus.d_ack;
      @(negedge clk);
      got = bus.if_ack;
      t++;
      @(posedge clk); #1;
    end
    chk1("starve_fetch_ack", got, 1'b1);
    bus.if_req = 1'b0;
  endtask
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      ack_now   = pend_port;
      pend_port = -1;
      if (post_rst) begin
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk1("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        post_rst = 0;
      end
      if (ack_now >= 0) begin
        r_exp = cur.wt >= TIMEOUT ? 32'h0 : (ack_now == 1 && cur.we) ? d_last : mem_f(cur.addr);
        if (cur.wt >= TIMEOUT) err_exp = 1'b1;
        if (ack_now == 0) i_last = r_exp;
        else d_last = r_exp;
        chk1("mem_req_drop", bus.mem_req, 1'b0);
      end
      chk1("if_ack", bus.if_ack, ack_now == 0);
      chk1("d_ack", bus.d_ack, ack_now == 1);
      chk("if_rdata", bus.if_rdata, i_last);
      chk("d_rdata", bus.d_rdata, d_last);
      chk1("err", bus.err, err_exp);
      chk1("stall_if", bus.stall_if, bus.if_req && ack_now != 0);
      chk1("stall_mem", bus.stall_mem, bus.d_req && ack_now != 1);
      if (exp_port >= 0) begin
        chk1("grant", bus.mem_req, 1'b1);
        if (exp_port == 0 && fq.size() > 0) cur = fq.pop_front();
        else if (exp_port == 1 && dq.size() > 0) cur = dq.pop_front();
        else chk1("grant_queue", 1'b0, 1'b1);
        chk("grant_addr", bus.mem_addr, cur.addr);
        chk1("grant_we", bus.mem_we, cur.we);
        if (cur.we) chk("grant_wdata", bus.mem_wdata, cur.wdata);
        active   = 1;
        k        = 0;
        cur_port = exp_port;
      end else if (!active) chk1("no_grant", bus.mem_req, 1'b0);
      idle = !active;
      if (active) begin
        last_k = cur.wt < TIMEOUT ? cur.wt : TIMEOUT - 1;
        chk1("mem_req_hold", bus.mem_req, 1'b1);
        chk("mem_addr_hold", bus.mem_addr, cur.addr);
        chk1("mem_we_hold", bus.mem_we, cur.we);
        bus.mem_ready = k == last_k && cur.wt < TIMEOUT;
        bus.mem_rdata = mem_f(cur.addr);
        if (k == last_k) begin
          pend_port = cur_port;
          active    = 0;
        end
        k++;
      end else begin
        bus.mem_ready = 1'($urandom);
        bus.mem_rdata = $urandom;
      end
      exp_port = -1;
      if (idle) begin
        iw = bus.if_req && ack_now != 0;
        dw = bus.d_req && ack_now != 1;
        if (iw && (!dw || starve == STARVE_LIMIT)) begin
          exp_port = 0;
          starve   = 0;
        end else if (dw) begin
          exp_port = 1;
          starve   = !iw ? 0 : starve < STARVE_LIMIT ? starve + 1 : STARVE_LIMIT;
        end
      end
      if (reset) begin
        active    = 0;
        pend_port = -1;
        exp_port  = -1;
        starve    = 0;
        err_exp   = 1'b0;
        i_last    = '0;
        d_last    = '0;
        fq.delete();
        dq.delete();
        post_rst  = 1;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", compared, mismatched);
    $fatal(1, "watchdog expired");
  end
  initial begin
    int t;
    reset       = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    fetch_txn(32'h40, 0);
    fork
      fetch_txn(32'h200, 0);
      data_txn(1'b1, 32'h10, 32'h7, 0);
    join
    data_txn(1'b0, 32'h8000_0040, 32'h0, 3);
    data_txn(1'b0, 32'h8000_0080, 32'h0, TIMEOUT);
    data_txn(1'b0, 32'h8000_00C0, 32'h0, TIMEOUT - 1);
    fork
      data_rand(6, 0, 1'b0);
      starve_fetch();
    join
    fq.push_back('{addr: 32'h100, we: 1'b0, wdata: 32'h0, wt: 1});
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.mem_req && t < 50);
    chk1("rst_mid_grant", bus.mem_req, 1'b1);
    @(posedge clk); #1;
    reset      = 1'b1;
    bus.if_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    fetch_txn(32'h44, 0);
    fork
      fetch_rand(40);
      data_rand(40, 3, 1'b1);
    join
    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum number of consecutive data-port grants while a fetch request waits.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum number of BUSY cycles without mem_ready before the access is aborted.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports if_req (in, 1), if_addr (in, 32), if_rdata (out, 32), if_ack (out, 1): the instruction-fetch requester, read-only.
REQ-006 SHALL have ports d_req (in, 1), d_we (in, 1), d_addr (in, 32), d_wdata (in, 32), d_rdata (out, 32), d_ack (out, 1): the MEM-stage data requester.
REQ-007 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, 32), mem_wdata (out, 32), mem_rdata (in, 32), mem_ready (in, 1): the single shared memory port.
REQ-008 SHALL have ports stall_if (out, 1), stall_mem (out, 1) and err (out, 1): pipeline stall requests and a timeout flag.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY_I and BUSY_D.
REQ-010 In IDLE, SHALL sample requests at the clock edge and grant one: data beats fetch, unless starve_cnt == STARVE_LIMIT and if_req is high, in which case fetch wins.
REQ-011 On grant, SHALL latch the address, we and wdata into mem_* registers, assert mem_req from the next cycle, and enter BUSY_I or BUSY_D.
REQ-012 SHALL hold mem_req and the latched mem_addr/mem_we/mem_wdata stable while in BUSY, independent of requester inputs.
REQ-013 SHALL force mem_we to 0 for fetch grants.
REQ-014 On the edge where mem_ready=1 in BUSY_x: SHALL register x_rdata <= mem_rdata (d_rdata unchanged on writes), pulse x_ack high for exactly one cycle, drop mem_req, and return to IDLE.
REQ-015 Latency: request sampled at edge N with mem_ready high in the first mem_req cycle SHALL give ack high in cycle N+2; each extra wait cycle adds 1.
REQ-016 In the cycle x_ack is high, SHALL mask x_req from arbitration; the other port may be granted in that same cycle (back-to-back, no idle bubble).
REQ-017 starve_cnt SHALL increment on each data grant made while if_req is high, saturate at STARVE_LIMIT, and clear on any fetch grant or when if_req is low at a data grant.
REQ-018 stall_if SHALL equal if_req & ~if_ack, combinationally; stall_mem SHALL equal d_req & ~d_ack, combinationally.
REQ-019 SHALL count BUSY cycles with mem_ready low in a 4-bit counter; when it reaches TIMEOUT, SHALL abort: x_ack pulses with x_rdata = 0, err is set sticky, mem_req drops, and the FSM returns to IDLE.
REQ-020 A mem_ready arriving while in IDLE SHALL be ignored.
REQ-021 The timeout counter SHALL clear on every grant.
REQ-022 Simultaneous if_req and d_req with no starvation SHALL result in d granted first, then if granted in the d_ack cycle.
REQ-023 Requesters SHALL hold req and operands until ack; req deasserting mid-BUSY SHALL NOT cancel the access.

Reset
REQ-024 When reset is high at an edge: state = IDLE; mem_req, mem_we, if_ack, d_ack and err = 0; mem_addr, mem_wdata, if_rdata and d_rdata = 0; starve_cnt and timeout counter = 0.
REQ-025 Reset mid-BUSY SHALL abandon the access, with no ack pulse afterwards.
REQ-026 Reset SHALL dominate mem_ready and req arriving in the same cycle.

Verification
REQ-027 Fetch only: if_req=1, if_addr=0x40, mem_ready high the first cycle with mem_rdata=0x012A4820 -> if_ack at N+2, if_rdata=0x012A4820, mem_we=0.
REQ-028 Collision: if_req=d_req=1 at same edge, d_we=1, d_addr=0x10, d_wdata=7 -> mem_addr 0x10 with we=1 first; d_ack, then if granted in the d_ack cycle; stall_if high until if_ack.
REQ-029 Starvation: d_req held high with d_ack back-to-back and if_req held high -> after 4 data grants, 5th grant goes to fetch; starve_cnt then returns to 0.
REQ-030 Timeout: d_req, mem_ready held low -> after 15 BUSY cycles d_ack pulses, d_rdata=0, err=1 stays until reset.
REQ-031 Reset mid-op: reset asserted in cycle 2 of BUSY_I with mem_ready arriving the same cycle -> no if_ack; all outputs 0 next cycle; a fresh if_req is then served normally.
REQ-032 Wait states: mem_ready delayed 3 cycles -> mem_addr stable throughout, ack at N+5, exactly one ack pulse.
